// File: rtl/stride_seq.sv
// stride_seq: walks every (i,j) of a rows x cols extent through the stride generator and queues the returned addresses in a FIFO.
// Each element takes at least 4 cycles, and a full FIFO stalls the walk before WRITE. Define STRIDE_SEQ_ERR_ABORT_EN to abort the walk on m_err_i.
module stride_seq #(
  parameter int                      DataWidth    = 32,
  parameter int                      AddressWidth = 32,
  parameter int                      FifoDepth    = 4,
  parameter logic [AddressWidth-1:0] SlaveBase    = 32'h41000,
  parameter logic [AddressWidth-1:0] TargetAddr   = 32'h40000
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      s_req_i,
  input  logic [AddressWidth-1:0]   s_addr_i,
  input  logic                      s_we_i,
  input  logic [DataWidth/8-1:0]    s_be_i,
  input  logic [DataWidth-1:0]      s_wdata_i,
  output logic                      s_rvalid_o,
  output logic [DataWidth-1:0]      s_rdata_o,
  output logic                      s_err_o,
  output logic                      m_req_o,
  output logic [AddressWidth-1:0]   m_addr_o,
  output logic                      m_we_o,
  output logic [DataWidth/8-1:0]    m_be_o,
  output logic [DataWidth-1:0]      m_wdata_o,
  input  logic                      m_rvalid_i,
  input  logic [DataWidth-1:0]      m_rdata_i,
  input  logic                      m_err_i
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int LvlW = $clog2(FifoDepth + 1);
  localparam logic [PtrW-1:0]         PtrOne   = PtrW'(1);
  localparam logic [LvlW-1:0]         LvlOne   = LvlW'(1);
  localparam logic [LvlW-1:0]         LvlFull  = LvlW'(FifoDepth);
  localparam logic [AddressWidth-1:0] AddrCtrl = SlaveBase;
  localparam logic [AddressWidth-1:0] AddrDims = SlaveBase + AddressWidth'(4);
  localparam logic [AddressWidth-1:0] AddrStat = SlaveBase + AddressWidth'(8);
  localparam logic [AddressWidth-1:0] AddrPop  = SlaveBase + AddressWidth'(12);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WWAIT = 3'd2,
    READ  = 3'd3,
    RWAIT = 3'd4
  } state_e;

  state_e                 r_state;
  state_e                 w_state_d;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;
  logic [31:0]            r_dims;
  logic [15:0]            r_i;
  logic [15:0]            r_j;
  logic [15:0]            r_cnt;
  logic [DataWidth-1:0]   r_mem [FifoDepth];
  logic [PtrW-1:0]        r_wptr;
  logic [PtrW-1:0]        r_rptr;
  logic [LvlW-1:0]        r_level;
  logic                   r_s_rvalid;
  logic                   r_s_err;
  logic [DataWidth-1:0]   r_s_rdata;

  logic [15:0]            w_rows;
  logic [15:0]            w_cols;
  logic                   w_wr;
  logic                   w_rd;
  logic                   w_hit_ctrl;
  logic                   w_hit_dims;
  logic                   w_hit_stat;
  logic                   w_hit_pop;
  logic                   w_hit_any;
  logic                   w_fifo_empty;
  logic                   w_dims_zero;
  logic                   w_start;
  logic                   w_start_go;
  logic                   w_dims_we;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_resp_err;
  logic                   w_abort;
  logic                   w_j_wrap;
  logic                   w_last;
  logic                   w_m_req;
  logic                   w_m_we;
  logic                   w_s_err_d;
  logic [LvlW-1:0]        w_level_d;
  logic [2:0]             w_lvl3;
  logic [31:0]            w_status;
  logic [DataWidth-1:0]   w_rdata_d;

`ifdef STRIDE_SEQ_ERR_ABORT_EN
  assign w_resp_err = m_err_i;
`else
  logic w_unused_err;
  assign w_unused_err = m_err_i;
  assign w_resp_err   = 1'b0;
`endif

  // Slave decode: only the four exact word addresses are mapped.
  assign w_rows       = r_dims[15:0];
  assign w_cols       = r_dims[31:16];
  assign w_wr         = s_req_i & s_we_i;
  assign w_rd         = s_req_i & ~s_we_i;
  assign w_hit_ctrl   = (s_addr_i == AddrCtrl);
  assign w_hit_dims   = (s_addr_i == AddrDims);
  assign w_hit_stat   = (s_addr_i == AddrStat);
  assign w_hit_pop    = (s_addr_i == AddrPop);
  assign w_hit_any    = w_hit_ctrl | w_hit_dims | w_hit_stat | w_hit_pop;
  assign w_fifo_empty = (r_level == '0);
  assign w_dims_zero  = (w_rows == 16'd0) | (w_cols == 16'd0);
  assign w_start      = w_wr & w_hit_ctrl & s_be_i[0] & s_wdata_i[0] & ~r_busy;
  assign w_start_go   = w_start & ~w_dims_zero;
  assign w_dims_we    = w_wr & w_hit_dims & ~r_busy;
  assign w_pop        = w_rd & w_hit_pop & ~w_fifo_empty;
  assign w_s_err_d    = ~w_hit_any | (w_rd & w_hit_pop & w_fifo_empty);

  assign w_push       = (r_state == RWAIT) & m_rvalid_i & ~w_resp_err;
  assign w_abort      = ((r_state == WWAIT) | (r_state == RWAIT)) & m_rvalid_i & w_resp_err;
  assign w_j_wrap     = (r_j == w_cols - 16'd1);
  assign w_last       = (r_i == w_rows - 16'd1) & w_j_wrap;

  assign w_lvl3       = 3'(r_level);
  assign w_status     = {r_cnt, 5'd0, w_lvl3, 5'd0, r_err, r_done, r_busy};

  always_comb begin
    w_level_d = r_level;
    if (w_push && !w_pop) begin
      w_level_d = r_level + LvlOne;
    end else if (!w_push && w_pop) begin
      w_level_d = r_level - LvlOne;
    end
  end

  always_comb begin
    w_rdata_d = '0;
    if (w_rd) begin
      if (w_hit_dims) begin
        w_rdata_d = r_dims;
      end else if (w_hit_stat) begin
        w_rdata_d = w_status;
      end else if (w_pop) begin
        w_rdata_d = r_mem[r_rptr];
      end
    end
  end

  // IDLE with r_busy set is the FIFO-full stall between elements.
  always_comb begin
    w_state_d = r_state;
    w_m_req   = 1'b0;
    w_m_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if ((w_start_go || r_busy) && (r_level < LvlFull)) begin
          w_state_d = WRITE;
        end
      end
      WRITE: begin
        w_m_req   = 1'b1;
        w_m_we    = 1'b1;
        w_state_d = WWAIT;
      end
      WWAIT: begin
        if (m_rvalid_i) begin
          w_state_d = w_resp_err ? IDLE : READ;
        end
      end
      READ: begin
        w_m_req   = 1'b1;
        w_state_d = RWAIT;
      end
      RWAIT: begin
        if (m_rvalid_i) begin
          if (w_resp_err || w_last) begin
            w_state_d = IDLE;
          end else if (w_level_d < LvlFull) begin
            w_state_d = WRITE;
          end else begin
            w_state_d = IDLE;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_dims  <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_busy <= ~w_dims_zero;
        r_done <= w_dims_zero;
        r_err  <= 1'b0;
        r_cnt  <= '0;
        r_i    <= '0;
        r_j    <= '0;
      end else begin
        if (w_abort) begin
          r_err  <= 1'b1;
          r_busy <= 1'b0;
        end
        if (w_push) begin
          if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
          end
          if (w_j_wrap) begin
            r_j <= '0;
            r_i <= r_i + 16'd1;
          end else begin
            r_j <= r_j + 16'd1;
          end
          if (w_last) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
      end
      if (w_dims_we) begin
        for (int b = 0; b < 4; b++) begin
          if (s_be_i[b]) begin
            r_dims[8*b +: 8] <= s_wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrOne;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrOne;
      end
      r_level <= w_level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= m_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s_rvalid <= 1'b0;
      r_s_err    <= 1'b0;
      r_s_rdata  <= '0;
    end else begin
      r_s_rvalid <= s_req_i;
      r_s_err    <= s_req_i & w_s_err_d;
      r_s_rdata  <= w_rdata_d;
    end
  end

  assign s_rvalid_o = r_s_rvalid;
  assign s_err_o    = r_s_err;
  assign s_rdata_o  = r_s_rdata;
  assign m_req_o    = w_m_req;
  assign m_we_o     = w_m_we;
  assign m_addr_o   = TargetAddr;
  assign m_be_o     = '1;
  assign m_wdata_o  = (r_state == WRITE) ? {r_j, r_i} : '0;

endmodule

// File: tb/tb_stride_seq.sv
// Directed + randomized bench for stride_seq with a latency-randomized generator model on the master port.
module tb_stride_seq;

  localparam logic [31:0] BASE = 32'h41000;
  localparam logic [31:0] TGT  = 32'h40000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        s_req_i = 1'b0;
  logic [31:0] s_addr_i = '0;
  logic        s_we_i = 1'b0;
  logic [3:0]  s_be_i = '0;
  logic [31:0] s_wdata_i = '0;
  logic        s_rvalid_o;
  logic [31:0] s_rdata_o;
  logic        s_err_o;
  logic        m_req_o;
  logic [31:0] m_addr_o;
  logic        m_we_o;
  logic [3:0]  m_be_o;
  logic [31:0] m_wdata_o;
  logic        m_rvalid_i;
  logic [31:0] m_rdata_i;
  logic        m_err_i;

  stride_seq dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .s_req_i    (s_req_i),
    .s_addr_i   (s_addr_i),
    .s_we_i     (s_we_i),
    .s_be_i     (s_be_i),
    .s_wdata_i  (s_wdata_i),
    .s_rvalid_o (s_rvalid_o),
    .s_rdata_o  (s_rdata_o),
    .s_err_o    (s_err_o),
    .m_req_o    (m_req_o),
    .m_addr_o   (m_addr_o),
    .m_we_o     (m_we_o),
    .m_be_o     (m_be_o),
    .m_wdata_o  (m_wdata_o),
    .m_rvalid_i (m_rvalid_i),
    .m_rdata_i  (m_rdata_i),
    .m_err_i    (m_err_i)
  );

  always #5 clk_i = ~clk_i;

  int          n_tests = 0;
  int          n_fail = 0;
  int          n_req = 0;
  int          n_wr = 0;
  int          n_rd_resp = 0;
  int          err_on_rd = 0;
  int          g_cols = 1;
  logic [31:0] g_sr = 32'd2;
  logic [31:0] g_sc = 32'd2;
  int          g_wait = 0;
  logic        g_we = 1'b0;
  int          g_i = 0;
  int          g_j = 0;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] gen_addr(input int i, input int j);
    return TGT + 32'(i) * g_sr + 32'(j) * g_sc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Generator model: latches (i,j) on writes, answers reads with its address after 1-3 cycles.
  initial begin
    m_rvalid_i = 1'b0;
    m_rdata_i  = '0;
    m_err_i    = 1'b0;
    forever begin
      @(negedge clk_i);
      m_rvalid_i = 1'b0;
      m_err_i    = 1'b0;
      m_rdata_i  = '0;
      if (g_wait > 0) begin
        g_wait--;
        if (g_wait == 0) begin
          m_rvalid_i = 1'b1;
          if (!g_we) begin
            n_rd_resp++;
            m_rdata_i = gen_addr(g_i, g_j);
            m_err_i   = (n_rd_resp == err_on_rd);
          end
        end
      end
      if (m_req_o) begin
        n_req++;
        chk("m_addr", m_addr_o, TGT);
        chk("m_be", 32'(m_be_o), 32'hF);
        g_we = m_we_o;
        if (m_we_o) begin
          chk("m_wdata_idx", m_wdata_o, {16'(n_wr % g_cols), 16'(n_wr / g_cols)});
          g_i = int'(m_wdata_o[15:0]);
          g_j = int'(m_wdata_o[31:16]);
          n_wr++;
        end else begin
          chk("m_rd_wdata", m_wdata_o, 32'd0);
        end
        g_wait = $urandom_range(1, 3);
      end
    end
  end

  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output logic e);
    @(negedge clk_i);
    s_req_i   = 1'b1;
    s_we_i    = we;
    s_addr_i  = addr;
    s_wdata_i = wd;
    s_be_i    = be;
    @(negedge clk_i);
    s_req_i   = 1'b0;
    s_we_i    = 1'b0;
    s_addr_i  = '0;
    s_wdata_i = '0;
    s_be_i    = '0;
    chk("s_rvalid", 32'(s_rvalid_o), 32'd1);
    rd = s_rdata_o;
    e  = s_err_o;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    logic        e;
    bus(1'b1, addr, wd, 4'hF, rd, e);
    chk("wr_err", 32'(e), 32'd0);
  endtask

  task automatic rd_reg(input logic [31:0] addr, output logic [31:0] rd);
    logic e;
    bus(1'b0, addr, 32'd0, 4'hF, rd, e);
    chk("rd_err", 32'(e), 32'd0);
  endtask

  task automatic start_walk(input int rows, input int cols);
    g_cols    = (cols == 0) ? 1 : cols;
    n_wr      = 0;
    n_rd_resp = 0;
    exp_q.delete();
    for (int i = 0; i < rows; i++)
      for (int j = 0; j < cols; j++)
        exp_q.push_back(gen_addr(i, j));
    wr(BASE + 32'h4, {16'(cols), 16'(rows)});
    wr(BASE, 32'd1);
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int guard;
    guard = 0;
    st = 32'd1;
    while (st[0] && guard < 500) begin
      rd_reg(BASE + 32'h8, st);
      guard++;
    end
    chk("idle_timeout", 32'(st[0]), 32'd0);
  endtask

  task automatic drain(input int n_elem);
    logic [31:0] st;
    logic [31:0] v;
    logic        e;
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 3000) begin
      guard++;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk_i);
      end else begin
        rd_reg(BASE + 32'h8, st);
        if (st[10:8] != 3'd0) begin
          bus(1'b0, BASE + 32'hC, 32'd0, 4'hF, v, e);
          chk("pop_err", 32'(e), 32'd0);
          chk("pop_data", v, exp_q.pop_front());
        end
      end
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    wait_idle();
    rd_reg(BASE + 32'h8, st);
    chk("done_status", st, {16'(n_elem), 16'h0002});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st;
    logic [31:0] v;
    logic        e;
    int          n0;
    int          guard;
    int          rows;
    int          cols;

    #1;
    chk("rst_s_rvalid", 32'(s_rvalid_o), 32'd0);
    chk("rst_s_rdata", s_rdata_o, 32'd0);
    chk("rst_s_err", 32'(s_err_o), 32'd0);
    chk("rst_m_req", 32'(m_req_o), 32'd0);
    chk("rst_m_we", 32'(m_we_o), 32'd0);
    chk("rst_m_wdata", m_wdata_o, 32'd0);
    chk("rst_m_addr", m_addr_o, TGT);
    chk("rst_m_be", 32'(m_be_o), 32'hF);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    rd_reg(BASE + 32'h8, st);
    chk("rst_status", st, 32'd0);

    // Register access: DIMS byte merge, CTRL reads 0.
    wr(BASE + 32'h4, 32'h0003_0002);
    bus(1'b1, BASE + 32'h4, 32'hAABB_CCDD, 4'b0010, v, e);
    rd_reg(BASE + 32'h4, v);
    chk("dims_merge", v, 32'h0003_CC02);
    rd_reg(BASE, v);
    chk("ctrl_read", v, 32'd0);

    // Basic 2x3 walk with strides 2/2.
    g_sr = 32'd2;
    g_sc = 32'd2;
    start_walk(2, 3);
    rd_reg(BASE + 32'h4, v);
    chk("dims_read", v, 32'h0003_0002);
    rd_reg(BASE + 32'h8, st);
    chk("busy_after_start", 32'(st[0]), 32'd1);
    drain(6);

    // Backpressure: no pops, walk parks with a full FIFO.
    n0 = n_req;
    start_walk(2, 3);
    repeat (150) @(negedge clk_i);
    chk("bp_reqs", 32'(n_req - n0), 32'd8);
    rd_reg(BASE + 32'h8, st);
    chk("bp_status", st, 32'h0004_0401);
    wr(BASE + 32'h4, 32'h0009_0009);
    rd_reg(BASE + 32'h4, v);
    chk("dims_busy_ignored", v, 32'h0003_0002);
    wr(BASE, 32'd1);
    repeat (60) @(negedge clk_i);
    chk("bp_hold", 32'(n_req - n0), 32'd8);
    rd_reg(BASE + 32'hC, v);
    chk("bp_pop", v, exp_q.pop_front());
    repeat (60) @(negedge clk_i);
    chk("bp_one_more", 32'(n_req - n0), 32'd10);
    rd_reg(BASE + 32'h8, st);
    chk("bp_status2", st, 32'h0005_0401);
    drain(6);

    // Zero extent: done at once, no master traffic.
    n0 = n_req;
    start_walk(5, 0);
    rd_reg(BASE + 32'h8, st);
    chk("zero_status", st, 32'h0000_0002);
    repeat (20) @(negedge clk_i);
    chk("zero_no_req", 32'(n_req - n0), 32'd0);

    // Error responses on the slave port.
    bus(1'b0, BASE + 32'hC, 32'd0, 4'hF, v, e);
    chk("empty_pop_data", v, 32'd0);
    chk("empty_pop_err", 32'(e), 32'd1);
    bus(1'b0, BASE + 32'h10, 32'd0, 4'hF, v, e);
    chk("unmapped_data", v, 32'd0);
    chk("unmapped_err", 32'(e), 32'd1);
    wr(BASE + 32'h8, 32'hFFFF_FFFF);
    wr(BASE + 32'hC, 32'hFFFF_FFFF);

    // Master error on the 2nd read response.
    start_walk(2, 3);
    err_on_rd = 2;
`ifdef STRIDE_SEQ_ERR_ABORT_EN
    wait_idle();
    rd_reg(BASE + 32'h8, st);
    chk("abort_status", st, 32'h0001_0104);
    rd_reg(BASE + 32'hC, v);
    chk("abort_fifo", v, 32'h0004_0000);
`else
    drain(6);
`endif
    err_on_rd = 0;

    // Reset while waiting on a read response.
    g_sr = 32'($urandom_range(1, 64)) << 2;
    g_sc = 32'($urandom_range(1, 64)) << 2;
    start_walk(3, 4);
    guard = 0;
    while (!(m_req_o && !m_we_o) && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    chk("rwait_reached", 32'(guard < 200), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("mid_s_rvalid", 32'(s_rvalid_o), 32'd0);
    chk("mid_s_rdata", s_rdata_o, 32'd0);
    chk("mid_s_err", 32'(s_err_o), 32'd0);
    chk("mid_m_req", 32'(m_req_o), 32'd0);
    chk("mid_m_wdata", m_wdata_o, 32'd0);
    chk("mid_m_addr", m_addr_o, TGT);
    @(negedge clk_i);
    rst_ni = 1'b1;
    rd_reg(BASE + 32'h8, st);
    chk("mid_status", st, 32'd0);
    repeat (10) @(negedge clk_i);
    start_walk(2, 3);
    drain(6);

    // Randomized extents and strides.
    for (int k = 0; k < 4; k++) begin
      rows = $urandom_range(1, 3);
      cols = $urandom_range(1, 5);
      g_sr = 32'($urandom_range(0, 255)) << 2;
      g_sc = 32'($urandom_range(0, 255)) << 2;
      start_walk(rows, cols);
      drain(rows * cols);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
